// File: rtl/i2c_slave_responder.sv
// I2C target with 7-bit address match, auto-incrementing pointer and a small register file.
// Optional `I2C_SLAVE_GENERAL_CALL_EN`: also ACK write-only general call (address byte 0x00).
module i2c_slave_responder #(
  parameter logic [6:0]  I2C_ADDR  = 7'h12,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         busy_o,
  output logic                         rx_valid_o,
  output logic [7:0]                   rx_data_o,
  output logic [$clog2(MEM_DEPTH)-1:0] rx_addr_o
);

  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_scl_s1, r_scl_s2, r_scl_d;
  logic               r_sda_s1, r_sda_s2, r_sda_d;
  logic [6:0]         r_shift;
  logic [2:0]         r_cnt, w_cnt_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_first, w_first_nxt;
  logic               r_sda_o, w_sda_nxt;
  logic               r_busy, w_busy_nxt;
  logic [7:0]         r_tx;
  logic [PTR_W-1:0]   r_ptr;
  logic [7:0]         r_mem [MEM_DEPTH];
  logic               r_rx_valid;
  logic [7:0]         r_rx_data;
  logic [PTR_W-1:0]   r_rx_addr;

  logic               w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]         w_byte, w_mem_rd;
  logic               w_last_bit, w_addr_hit, w_gc_hit;
  logic               w_shift_en, w_ptr_ld, w_ptr_inc, w_mem_we, w_tx_ld;

  // Bus synchronizers; idle-high reset values avoid false edges after reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_last_bit = (r_cnt == 3'd7);
  assign w_addr_hit = (w_byte[7:1] == I2C_ADDR);
  assign w_mem_rd   = r_mem[r_ptr];

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign w_gc_hit = (w_byte == 8'h00);
`else
  assign w_gc_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus datapath strobes; START/STOP take priority over bit activity
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_first_nxt = r_first;
    w_sda_nxt   = r_sda_o;
    w_busy_nxt  = r_busy;
    w_shift_en  = 1'b0;
    w_ptr_ld    = 1'b0;
    w_ptr_inc   = 1'b0;
    w_mem_we    = 1'b0;
    w_tx_ld     = 1'b0;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_sda_nxt   = 1'b1;
      w_busy_nxt  = 1'b0;
      w_phase_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = 3'd0;
      w_sda_nxt   = 1'b1;
      w_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            w_cnt_nxt  = 3'(r_cnt + 3'd1);
            if (w_last_bit) begin
              w_cnt_nxt   = 3'd0;
              w_phase_nxt = 1'b0;
              if (w_addr_hit || w_gc_hit) begin
                w_state_nxt = ST_ADDR_ACK;
                w_busy_nxt  = 1'b1;
                w_first_nxt = ~w_gc_hit;
              end else begin
                w_state_nxt = ST_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // First SCL fall drives ACK, second ends the ACK clock
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_nxt   = 1'b0;
              w_phase_nxt = 1'b1;
            end else begin
              w_phase_nxt = 1'b0;
              if (r_shift[0]) begin
                w_state_nxt = ST_RD_BYTE;
                w_tx_ld     = 1'b1;
                w_sda_nxt   = w_mem_rd[7];
              end else begin
                w_state_nxt = ST_WR_BYTE;
                w_sda_nxt   = 1'b1;
              end
            end
          end
        end
        ST_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            w_cnt_nxt  = 3'(r_cnt + 3'd1);
            if (w_last_bit) begin
              w_cnt_nxt   = 3'd0;
              w_phase_nxt = 1'b0;
              w_state_nxt = ST_WR_ACK;
              w_first_nxt = 1'b0;
              if (r_first) begin
                w_ptr_ld = 1'b1;
              end else begin
                w_mem_we  = 1'b1;
                w_ptr_inc = 1'b1;
              end
            end
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_nxt   = 1'b0;
              w_phase_nxt = 1'b1;
            end else begin
              w_sda_nxt   = 1'b1;
              w_phase_nxt = 1'b0;
              w_state_nxt = ST_WR_BYTE;
            end
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_rise) begin
            w_cnt_nxt = 3'(r_cnt + 3'd1);
            if (w_last_bit) begin
              w_cnt_nxt   = 3'd0;
              w_phase_nxt = 1'b0;
              w_ptr_inc   = 1'b1;
              w_state_nxt = ST_RD_ACK;
            end
          end else if (w_scl_fall) begin
            w_sda_nxt = r_tx[3'd7 - r_cnt];
          end
        end
        ST_RD_ACK: begin
          // Release on the fall after bit 8, sample master ACK, reload on the following fall
          if (w_scl_rise) begin
            if (r_sda_s2) w_state_nxt = ST_IGNORE;
            else          w_phase_nxt = 1'b1;
          end else if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_nxt = 1'b1;
            end else begin
              w_phase_nxt = 1'b0;
              w_tx_ld     = 1'b1;
              w_sda_nxt   = w_mem_rd[7];
              w_state_nxt = ST_RD_BYTE;
            end
          end
        end
        ST_IDLE, ST_IGNORE: begin
          w_sda_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_sda_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_first    <= 1'b0;
      r_sda_o    <= 1'b1;
      r_busy     <= 1'b0;
      r_tx       <= '0;
      r_ptr      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_addr  <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_first    <= w_first_nxt;
      r_sda_o    <= w_sda_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_valid <= w_mem_we;
      if (w_shift_en) r_shift <= w_byte[6:0];
      if (w_tx_ld)    r_tx    <= w_mem_rd;
      if (w_ptr_ld)       r_ptr <= w_byte[PTR_W-1:0];
      else if (w_ptr_inc) r_ptr <= r_ptr + PTR_W'(1);
      if (w_mem_we) begin
        r_rx_data <= w_byte;
        r_rx_addr <= r_ptr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      r_mem <= '{default: '0};
    else if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  assign sda_o      = r_sda_o;
  assign busy_o     = r_busy;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign rx_addr_o  = r_rx_addr;

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

Synthesizable I2C target that answers an I2C master, such as the multi-bus controller, on one bus line. It detects START, repeated START and STOP, matches a 7-bit address, and ACKs address and write bytes. It stores written bytes in a 16-byte register file through an auto-incrementing pointer and serves read bytes from the same file. It replaces the behavioural I2C slave model, so directed benches can pair the controller with real RTL on the far end.

## Interface
- `I2C_ADDR`, default 7'h12: target address this block ACKs.
- `MEM_DEPTH`, default 16: register file depth. Must be a power of two. Pointer width is log2(MEM_DEPTH).
- `clk_i`, in, 1: system clock. 100 MHz nominal.
- `rst_n_i`, in, 1: asynchronous, active-low reset.
- `scl_i`, in, 1: I2C clock from the bus.
- `sda_i`, in, 1: I2C data from the bus.
- `sda_o`, out, 1: open-drain data drive. 0 pulls the bus low; 1 releases it to the pull-up.
- `busy_o`, out, 1: high from an address-matched ACK until STOP or a non-matching restart.
- `rx_valid_o`, out, 1: one-cycle pulse when a data byte is written into the register file.
- `rx_data_o`, out, 8: byte just written. Valid while `rx_valid_o` is high.
- `rx_addr_o`, out, log2(MEM_DEPTH): file index of that byte.

## Operation
- **Input sampling:** `scl_i` and `sda_i` each pass through a 2-flop synchronizer plus one edge-detect register. All decisions use the synchronized copies.
- **START:** SDA falling while SCL is high. Legal in any state; goes to ADDR and clears the bit counter.
- **STOP:** SDA rising while SCL is high. Legal in any state; goes to IDLE and releases `sda_o`.
- **State machine:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- **ADDR:** shift 8 bits MSB first on SCL rising edges.
  - Bits[7:1] == `I2C_ADDR`: go to ADDR_ACK.
  - Otherwise: go to IGNORE (`sda_o`=1 until the next START or STOP).
- **ADDR_ACK:** drive `sda_o`=0 for one SCL period, then:
  - bit0=0 goes to WR_BYTE; the first-byte flag is set.
  - bit0=1 goes to RD_BYTE; the byte at `mem[ptr]` is loaded.
- **WR_BYTE:** shift 8 bits, then go to WR_ACK and ACK.
  - First byte after the address: loads `ptr` (low log2(MEM_DEPTH) bits). Not stored, no `rx_valid_o`.
  - Later bytes: `mem[ptr]` gets the byte, `rx_valid_o` pulses, then `ptr` increments modulo MEM_DEPTH.
- **RD_BYTE:** drive bits MSB first, changing `sda_o` only while SCL is low; `ptr` increments after the 8th bit. Then go to RD_ACK, where `sda_o`=1 and the master's bit is sampled on SCL rising.
  - ACK (0): load the next byte, go to RD_BYTE.
  - NACK (1): go to IGNORE.
- **Pointer:** persists across transactions and STOPs; cleared only by reset. It wraps 0xF to 0x0 with no flag.
- **Repeated START** in WR_BYTE or RD_BYTE mid-byte discards the partial byte; `ptr` is unchanged.
- **Reset:** asynchronous, in any state.
  - State returns to IDLE and `ptr`=0.
  - Outputs go to `sda_o`=1, `busy_o`=0, `rx_valid_o`=0, `rx_data_o`=0, `rx_addr_o`=0.
  - `mem` is cleared to 0x00.
- **No clock stretching:** `scl_i` is input only.

## Timing
- Synchronizer plus edge detect adds 3 `clk_i` cycles of latency from a pin edge to internal event detection.
- **SDA changes:** `sda_o` updates on the cycle after an SCL falling edge is detected, i.e. at most 4 clk after SCL falls.
  - At 100 MHz and ≤400 kHz SCL this sits well inside the low phase.
  - `sda_o` never changes while synchronized SCL is high, except to release on STOP detection or reset.
- **ACK window:** driven from the SCL fall after bit 8 until the SCL fall after the ACK clock.
- **rx_valid_o:** asserted exactly one cycle, on the cycle after the SCL rising edge of bit 8 is detected. `rx_data_o` and `rx_addr_o` hold their values until the next write.
- **Simultaneous events:** START or STOP detection has priority over bit shifting in the same cycle.

## Configuration
- `I2C_SLAVE_GENERAL_CALL_EN` defined:
  - Address byte 0x00 is also ACKed, as write-only.
  - Following bytes are written starting at the current `ptr`, with no pointer-load byte.
  - Address 0x01 (read to general call) is NACKed and the block goes to IGNORE.
- Undefined: 0x00 is treated as a non-matching address and NACKed.

## Test plan
- **Write:** START, 0x24, 0x03, 0xA5, 0x5A, STOP.
  - Three ACKs.
  - `mem[3]`=0xA5, `mem[4]`=0x5A.
  - `rx_valid_o` pulses twice, with `rx_addr_o` 3 then 4.
  - `busy_o` falls on STOP.
- **Read with repeated START:** after the write above, START, 0x24, 0x03, repeated START, 0x25, read two bytes with master ACK then NACK.
  - Bus returns 0xA5 then 0x5A.
  - Afterwards `ptr`=5 and the block is in IGNORE until STOP.
- **Address mismatch:** START, 0x26, 0x11, STOP.
  - `sda_o` stays 1 throughout.
  - No `rx_valid_o`, `busy_o` stays 0.
- **Pointer wrap:** START, 0x24, 0x0F, 0x11, 0x22, 0x33, STOP.
  - `mem[15]`=0x11, `mem[0]`=0x22, `mem[1]`=0x33.
- **Reset mid-read:** assert `rst_n_i` low during bit 4 of a read byte whose current bit is 0.
  - `sda_o`=1 within the same cycle; `ptr`=0; `mem[0]`=0x00.
  - After release, the next address byte is ignored until a START.
- **General call:** with `I2C_SLAVE_GENERAL_CALL_EN` defined and `ptr`=2, send START, 0x00, 0x77, STOP.
  - ACKed, `mem[2]`=0x77.
  - Without the macro, 0x00 is NACKed.
